uart_buffered_tx: RTL

UART_BUFFERED_TX -- requirements
Module: uart_buffered_tx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 47 ++++
 rtl/uart_buffered_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter: frame FSM states and frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned START_BITS = 1;

  // Bit periods in one frame, used to size timing windows around a frame.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_bits,
                                             input int unsigned stop_bits);
    return START_BITS + data_bits + parity_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage carries no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered UART transmitter: FIFO-fed start/data/stop framer with sticky overflow.
// Define UART_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_buffered_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          clr_ovf,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  tx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] head;
  logic                 pop;
  logic                 bit_end;
  logic                 tx_d;
  logic                 done_d;
`ifdef UART_PARITY_EN
  logic                 par_q, par_d;
`else
  localparam bit unused_parity_odd = (PARITY_ODD != 0);
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             overflow <= 1'b0;
    else if (wr_en && full)   overflow <= 1'b1;
    else if (clr_ovf)         overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx      <= tx_d;
      tx_busy <= (state_q != IDLE);
      tx_done <= done_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Baud counter restarts at every bit boundary, which covers every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    if ((state_q != IDLE) && !bit_end) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          idx_d   = '0;
          state_d = START;
`ifdef UART_PARITY_EN
          par_d   = (^head) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shreg_q[0];
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          idx_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
